image_write: RTL and testbench
==============================

Name: image_write

Overview:
- Sink for processed RGB pixel streams, i.e. the writer counterpart of the image reader feeding our pixel-processing blocks (threshold, brightness, etc.).
- Accepts one 24-bit RGB pixel per handshake, in raster order: top row first, left to right.
- Serialises each pixel into byte writes on a frame-memory port in BMP pixel-array layout: BGR byte order, rows padded to 4-byte multiples, bottom-up row order by default.
- Pulses done after the last byte of a frame, then accepts the next frame.

Parameters:
- HEIGHT, 768, image rows.
- WIDTH, 512, image columns.
- BASE_ADDR, 54, byte address of the first pixel-array byte (BMP header size).
- BOTTOM_UP, 1, 1 = BMP row order (image row r stored at line HEIGHT-1-r); 0 = top-down.
- ADDR_W, 21, mem_addr width; must hold BASE_ADDR+HEIGHT*STRIDE-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  pixel valid.
- s_ready  output  1  block can accept a pixel.
- R  input  8  red.
- G  input  8  green.
- B  input  8  blue.
- mem_we  output  1  byte write strobe.
- mem_addr  output  ADDR_W  byte address.
- mem_data  output  8  byte data.
- done  output  1  one-cycle end-of-frame pulse.

Behaviour:
- Derived constants:
  - STRIDE = ((WIDTH*3+3)/4)*4.
  - PAD = STRIDE - WIDTH*3 (0..3).
  - LINE0 = BASE_ADDR + (BOTTOM_UP ? (HEIGHT-1)*STRIDE : 0).
- Reset (async assert, sync release):
  - state=IDLE, col=0, row=0, line_base=LINE0.
  - Registered outputs during reset: s_ready=0, mem_we=0, mem_addr=0, mem_data=0, done=0.
  - s_ready=1 from the first clock edge after release.
- States: IDLE, WB, WG, WR, PAD, DONE. All outputs are registered.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready, capture R/G/B into a holding register and go to WB.
  - s_ready drops in the cycle after acceptance.
- WB, WG, WR (one cycle each):
  - mem_we=1, mem_data=B, G, R respectively.
  - mem_addr = line_base + col*3 + 0, 1, 2.
  - Address is kept in a running byte pointer; no multiplier.
- After WR:
  - If col<WIDTH-1: col++, go to IDLE.
  - Else: col=0, go to PAD if PAD>0, otherwise take the end-of-row step directly.
- PAD: PAD consecutive cycles, each mem_we=1, mem_data=0, addresses continuing after the last R byte.
- End of row:
  - If row<HEIGHT-1: row++, line_base -= STRIDE (BOTTOM_UP=1) or += STRIDE (BOTTOM_UP=0), go to IDLE.
  - Else: go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - row=0, line_base=LINE0, go to IDLE. The next pixel starts a new frame.
- mem_we=0 in IDLE and DONE.
- Throughput: 4 cycles per pixel, plus PAD cycles per row, plus 1 cycle per frame.
- Latency: the B write appears 1 cycle after the accepting edge.
- s_valid while s_ready=0 is ignored: no capture and no side effects. The upstream holds data until accepted.
- R/G/B changes while not accepting have no effect (holding register).
- Reset mid-operation aborts the frame:
  - No further writes.
  - Counters return to frame start.
  - done is not pulsed.
- Degenerate sizes WIDTH=1 and/or HEIGHT=1 must work; HEIGHT=1 gives LINE0=BASE_ADDR.

Decomposition:
- Shared package img_pkg:
  - BMP_HDR_BYTES=54.
  - Function bmp_stride(width).
  - State enum type for the write FSM.
- Optional sub-module image_write_addr: owns line_base, byte pointer, col/row counters; exposes end-of-row and end-of-frame flags.

Test Plan:
- WIDTH=2, HEIGHT=2, BASE=54, BOTTOM_UP=1:
  - Stimulus: pixels (10,20,30), (40,50,60), (1,2,3), (4,5,6).
  - Writes: 62:30, 63:20, 64:10, 65:60, 66:50, 67:40, 68:0, 69:0, 54:3, 55:2, 56:1, 57:6, 58:5, 59:4, 60:0, 61:0.
  - Then done for 1 cycle; no other mem_we cycles.
- Same size, BOTTOM_UP=0 -> first row at 54..61, second row at 62..69, same data and padding.
- WIDTH=4, HEIGHT=1 (STRIDE=12, PAD=0) -> 12 contiguous writes at 54..65, no pad cycles, done 1 cycle after the last R byte.
- s_valid held high continuously -> s_ready pattern 1,0,0,0 per pixel; each pixel captured once; s_valid toggled while s_ready=0 causes no writes.
- Reset asserted during WG of pixel 3:
  - mem_we=0 and all outputs 0 immediately (asynchronous).
  - After release, the next pixel is written at LINE0.
  - No done pulse.
- Two back-to-back 2x2 frames -> done pulses twice; second frame addresses identical to the first.

Source files
------------

// File: rtl/img_pkg.sv
// img_pkg: shared BMP constants, row-stride helper and write-FSM state type.
package img_pkg;
  localparam int BMP_HDR_BYTES = 54;
  typedef enum logic [2:0] {IDLE, WB, WG, WR, PAD, DONE} wr_state_e;
  function automatic int bmp_stride(input int width);
    return ((width * 3 + 3) / 4) * 4;
  endfunction
endpackage

// File: rtl/image_write_addr.sv
// image_write_addr: column/row counters, line base and running byte pointer for the
// next pixel's B byte; flags the last column of a row and the last pixel of a frame.
module image_write_addr
  import img_pkg::*;
#(
  parameter int HEIGHT    = 768,
  parameter int WIDTH     = 512,
  parameter int BASE_ADDR = BMP_HDR_BYTES,
  parameter int BOTTOM_UP = 1,
  parameter int ADDR_W    = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              eor,
  input  logic              eof,
  output logic [ADDR_W-1:0] ptr,
  output logic              row_end,
  output logic              frame_end
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(bmp_stride(WIDTH));
  localparam logic [ADDR_W-1:0] LINE0 =
    ADDR_W'(BASE_ADDR + (BOTTOM_UP != 0 ? (HEIGHT - 1) * bmp_stride(WIDTH) : 0));
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] line_base, line_next;
  assign row_end   = col == CW'(WIDTH - 1);
  assign frame_end = row_end && row == RW'(HEIGHT - 1);
  assign line_next = BOTTOM_UP != 0 ? line_base - STRIDE : line_base + STRIDE;
  // col holds WIDTH-1 through the pad cycles so row_end stays valid until the row step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      line_base <= LINE0;
      ptr       <= LINE0;
    end else if (eof) begin
      col       <= '0;
      row       <= '0;
      line_base <= LINE0;
      ptr       <= LINE0;
    end else if (eor) begin
      col <= '0;
      if (!frame_end) begin
        row       <= row + RW'(1);
        line_base <= line_next;
        ptr       <= line_next;
      end
    end else if (adv && !row_end) begin
      col <= col + CW'(1);
      ptr <= ptr + ADDR_W'(3);
    end
endmodule

// File: rtl/image_write.sv
// image_write: serialises raster-order RGB pixels into BMP pixel-array byte writes
// (BGR order, rows padded to 4 bytes, bottom-up rows when BOTTOM_UP=1).
module image_write
  import img_pkg::*;
#(
  parameter int HEIGHT    = 768,
  parameter int WIDTH     = 512,
  parameter int BASE_ADDR = BMP_HDR_BYTES,
  parameter int BOTTOM_UP = 1,
  parameter int ADDR_W    = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              done
);
  localparam int PAD_BYTES = bmp_stride(WIDTH) - WIDTH * 3;
  localparam logic [1:0] PAD_LAST = 2'(PAD_BYTES - 1);
  wr_state_e state, state_n;
  logic [15:0] hold;
  logic [1:0] pad_cnt;
  logic [ADDR_W-1:0] ptr, addr_n;
  logic [7:0] data_n;
  logic accept, pad_last, adv, eor, eof, row_end, frame_end;
  assign accept   = s_valid && s_ready;
  assign pad_last = state == PAD && pad_cnt == PAD_LAST;
  assign adv      = state == WR;
  assign eor      = (adv && row_end && PAD_BYTES == 0) || pad_last;
  assign eof      = state == DONE;
  image_write_addr #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .BASE_ADDR(BASE_ADDR),
    .BOTTOM_UP(BOTTOM_UP), .ADDR_W(ADDR_W)
  ) u_addr (
    .clk(clk), .rst_n(rst_n), .adv(adv), .eor(eor), .eof(eof),
    .ptr(ptr), .row_end(row_end), .frame_end(frame_end)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? WB : IDLE;
      WB:      state_n = WG;
      WG:      state_n = WR;
      WR:      state_n = !row_end ? IDLE : PAD_BYTES > 0 ? PAD : frame_end ? DONE : IDLE;
      PAD:     state_n = !pad_last ? PAD : frame_end ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state, so B is written the cycle after acceptance
  assign addr_n = state_n == WB ? ptr :
                  state_n inside {WG, WR, PAD} ? mem_addr + ADDR_W'(1) : mem_addr;
  assign data_n = state_n == WB ? B : state_n == WG ? hold[7:0] :
                  state_n == WR ? hold[15:8] : 8'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      pad_cnt  <= '0;
      s_ready  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      if (accept) hold <= {R, G};
      pad_cnt  <= state == PAD && !pad_last ? pad_cnt + 2'd1 : 2'd0;
      s_ready  <= state_n == IDLE;
      mem_we   <= state_n inside {WB, WG, WR, PAD};
      mem_addr <= addr_n;
      mem_data <= data_n;
      done     <= state_n == DONE;
    end
endmodule

// File: tb/tb_image_write.sv
// tb_image_write: three image_write instances (2x2 bottom-up, 2x2 top-down, 4x1)
// checked against a table and a BMP-layout reference model.
module tb_image_write;
  typedef struct {int k; int a; int d; int cyc;} ev_t;
  typedef struct {int a; int d;} wr_t;
  typedef struct {logic [7:0] r; logic [7:0] g; logic [7:0] b; int a_bu; int a_td;} vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] s_valid, s_ready, mem_we, done;
  logic [2:0][7:0] r_in, g_in, b_in, mem_data;
  logic [2:0][20:0] mem_addr;

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt [3];
  int done_cyc [3];
  int dd [3];
  int mark, last_cyc, idx, a, p;
  bit pend;
  bit rlog[$];
  ev_t cap[$];
  wr_t got_q[$], exp_q[$];
  logic [23:0] pix_q[$];
  vec_t tv [4];

  image_write #(.HEIGHT(2), .WIDTH(2), .BASE_ADDR(54), .BOTTOM_UP(1), .ADDR_W(21)) u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .R(r_in[0]), .G(g_in[0]), .B(b_in[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .done(done[0]));
  image_write #(.HEIGHT(2), .WIDTH(2), .BASE_ADDR(54), .BOTTOM_UP(0), .ADDR_W(21)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .R(r_in[1]), .G(g_in[1]), .B(b_in[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .done(done[1]));
  image_write #(.HEIGHT(1), .WIDTH(4), .BASE_ADDR(54), .BOTTOM_UP(1), .ADDR_W(21)) u2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .R(r_in[2]), .G(g_in[2]), .B(b_in[2]), .mem_we(mem_we[2]),
    .mem_addr(mem_addr[2]), .mem_data(mem_data[2]), .done(done[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      if (mem_we[k]) cap.push_back('{k, int'(mem_addr[k]), int'(mem_data[k]), cyc});
      if (done[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
    end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_px(input int k, input logic [23:0] px);
    r_in[k] = px[23:16];
    g_in[k] = px[15:8];
    b_in[k] = px[7:0];
  endtask

  task automatic scramble(input logic [2:0] m);
    for (int k = 0; k < 3; k++) if (m[k]) set_px(k, 24'($urandom));
  endtask

  // present one pixel to every instance in m; noisy toggles valid/data while not ready
  task automatic drive(input logic [2:0] m, input logic [23:0] px, input bit noisy);
    int n;
    bit rdy;
    n = 0;
    do begin
      @(negedge clk);
      rdy = (s_ready & m) == m;
      if (rdy) begin
        s_valid = m;
        for (int k = 0; k < 3; k++) if (m[k]) set_px(k, px);
      end else begin
        s_valid = noisy ? 3'($urandom) & m : 3'b000;
        scramble(m);
      end
      n++;
    end while (!rdy && n < 60);
    chk("drive_accept", int'(rdy), 1);
    @(negedge clk);
    s_valid = noisy ? 3'($urandom) & m : 3'b000;
    scramble(m);
  endtask

  task automatic wait_done(input int k, input int target);
    int n;
    n = 0;
    while (done_cnt[k] < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen_u%0d", k), int'(done_cnt[k] >= target), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic collect(input int k, input int from);
    got_q.delete();
    last_cyc = -1;
    for (int i = from; i < cap.size(); i++)
      if (cap[i].k == k) begin
        got_q.push_back('{cap[i].a, cap[i].d});
        last_cyc = cap[i].cyc;
      end
  endtask

  // BMP layout: image row r lands on line H-1-r (bottom-up) or r, BGR per pixel, zero pad
  task automatic model(input int w, input int h, input int bu, input int nf);
    int stride, base, q;
    logic [23:0] px;
    stride = ((w * 3 + 3) / 4) * 4;
    q = 0;
    exp_q.delete();
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < h; r++) begin
        base = 54 + (bu != 0 ? h - 1 - r : r) * stride;
        for (int c = 0; c < w; c++) begin
          px = pix_q[q++];
          exp_q.push_back('{base + 3 * c, int'(px[7:0])});
          exp_q.push_back('{base + 3 * c + 1, int'(px[15:8])});
          exp_q.push_back('{base + 3 * c + 2, int'(px[23:16])});
        end
        for (int i = 3 * w; i < stride; i++) exp_q.push_back('{base + i, 0});
      end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_q[i].a, exp_q[i].a);
      chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic rand_pix(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(24'($urandom));
  endtask

  initial begin
    tv[0] = '{8'd10, 8'd20, 8'd30, 62, 54};
    tv[1] = '{8'd40, 8'd50, 8'd60, 65, 57};
    tv[2] = '{8'd1, 8'd2, 8'd3, 54, 62};
    tv[3] = '{8'd4, 8'd5, 8'd6, 57, 65};
    s_valid = '0;
    r_in = '0;
    g_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready_u%0d", k), int'(s_ready[k]), 0);
      chk($sformatf("rst_we_u%0d", k), int'(mem_we[k]), 0);
      chk($sformatf("rst_addr_u%0d", k), int'(mem_addr[k]), 0);
      chk($sformatf("rst_data_u%0d", k), int'(mem_data[k]), 0);
      chk($sformatf("rst_done_u%0d", k), int'(done[k]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_rst_u%0d", k), int'(s_ready[k]), 1);

    // table vectors on the 2x2 bottom-up and top-down instances
    mark = cap.size();
    dd[0] = done_cnt[0];
    dd[1] = done_cnt[1];
    for (int i = 0; i < 4; i++) drive(3'b011, {tv[i].r, tv[i].g, tv[i].b}, 1'b0);
    s_valid = '0;
    wait_done(0, dd[0] + 1);
    wait_done(1, dd[1] + 1);
    for (int u = 0; u < 2; u++) begin
      collect(u, mark);
      chk($sformatf("tab_count_u%0d", u), got_q.size(), 16);
      if (got_q.size() == 16)
        for (int i = 0; i < 4; i++) begin
          idx = i * 3 + (i / 2) * 2;
          a = u == 0 ? tv[i].a_bu : tv[i].a_td;
          chk($sformatf("tab_b_addr_u%0d_p%0d", u, i), got_q[idx].a, a);
          chk($sformatf("tab_b_data_u%0d_p%0d", u, i), got_q[idx].d, int'(tv[i].b));
          chk($sformatf("tab_g_addr_u%0d_p%0d", u, i), got_q[idx + 1].a, a + 1);
          chk($sformatf("tab_g_data_u%0d_p%0d", u, i), got_q[idx + 1].d, int'(tv[i].g));
          chk($sformatf("tab_r_addr_u%0d_p%0d", u, i), got_q[idx + 2].a, a + 2);
          chk($sformatf("tab_r_data_u%0d_p%0d", u, i), got_q[idx + 2].d, int'(tv[i].r));
          if (i % 2 == 1)
            for (int j = 3; j < 5; j++) begin
              chk($sformatf("tab_pad_addr_u%0d_p%0d", u, i), got_q[idx + j].a, a + j);
              chk($sformatf("tab_pad_data_u%0d_p%0d", u, i), got_q[idx + j].d, 0);
            end
        end
      chk($sformatf("tab_done_cnt_u%0d", u), done_cnt[u], dd[u] + 1);
      chk($sformatf("tab_done_lat_u%0d", u), done_cyc[u], last_cyc + 1);
    end

    // 4x1 frame, no padding, noisy valid while busy
    mark = cap.size();
    dd[2] = done_cnt[2];
    rand_pix(4);
    for (int i = 0; i < 4; i++) drive(3'b100, pix_q[i], 1'b1);
    s_valid = '0;
    wait_done(2, dd[2] + 1);
    model(4, 1, 1, 1);
    collect(2, mark);
    compare("w4h1");
    chk("w4h1_done_cnt", done_cnt[2], dd[2] + 1);
    chk("w4h1_done_lat", done_cyc[2], last_cyc + 1);

    // valid held high: ready must read 1,0,0,0 per pixel
    mark = cap.size();
    dd[2] = done_cnt[2];
    rand_pix(4);
    rlog.delete();
    pend = 1'b0;
    p = 0;
    @(negedge clk);
    s_valid[2] = 1'b1;
    set_px(2, pix_q[0]);
    for (int c = 0; c < 80 && p < 4; c++) begin
      if (pend) begin
        p++;
        pend = 1'b0;
        if (p < 4) set_px(2, pix_q[p]);
      end
      if (p < 4) begin
        rlog.push_back(s_ready[2]);
        pend = s_ready[2];
        @(negedge clk);
      end
    end
    s_valid = '0;
    chk("held_pixels", p, 4);
    chk("held_log_len", rlog.size(), 13);
    for (int i = 0; i < rlog.size() && i < 12; i++)
      chk($sformatf("held_ready%0d", i), int'(rlog[i]), int'(i % 4 == 0));
    wait_done(2, dd[2] + 1);
    model(4, 1, 1, 1);
    collect(2, mark);
    compare("held");

    // reset during WG of the third pixel aborts the frame
    mark = cap.size();
    dd[0] = done_cnt[0];
    rand_pix(3);
    for (int i = 0; i < 3; i++) drive(3'b001, pix_q[i], 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", int'(mem_we[0]), 0);
    chk("abort_addr", int'(mem_addr[0]), 0);
    chk("abort_data", int'(mem_data[0]), 0);
    chk("abort_ready", int'(s_ready[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    collect(0, mark);
    chk("abort_writes", got_q.size(), 9);
    chk("abort_no_done", done_cnt[0], dd[0]);
    mark = cap.size();
    rand_pix(4);
    for (int i = 0; i < 4; i++) drive(3'b001, pix_q[i], 1'b1);
    s_valid = '0;
    wait_done(0, dd[0] + 1);
    model(2, 2, 1, 1);
    collect(0, mark);
    compare("after_abort");
    chk("after_abort_done_cnt", done_cnt[0], dd[0] + 1);

    // two back-to-back frames on both 2x2 instances
    mark = cap.size();
    dd[0] = done_cnt[0];
    dd[1] = done_cnt[1];
    rand_pix(8);
    for (int i = 0; i < 8; i++) drive(3'b011, pix_q[i], 1'b1);
    s_valid = '0;
    wait_done(0, dd[0] + 2);
    wait_done(1, dd[1] + 2);
    for (int u = 0; u < 2; u++) begin
      model(2, 2, 1 - u, 2);
      collect(u, mark);
      compare($sformatf("b2b_u%0d", u));
      chk($sformatf("b2b_done_cnt_u%0d", u), done_cnt[u], dd[u] + 2);
      chk($sformatf("b2b_done_lat_u%0d", u), done_cyc[u], last_cyc + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
